// File: rtl/interp_pkg.sv
// Shared types and constants for the linear interpolating upsampler.
package interp_pkg;

  typedef enum logic [1:0] {
    EMPTY,
    PRIMED,
    EMIT
  } state_t;

  localparam int INTERP_VAL_RES     = 16;
  localparam int INTERP_LOG2_FACTOR = 2;

  // Upsampling factor N for a given log2 factor.
  function automatic int interp_n(input int log2_factor);
    return 1 << log2_factor;
  endfunction

endpackage

// File: rtl/interp_upsample.sv
// Linear interpolating upsampler: each input interval (prev -> cur) is expanded
// into N = 2^LOG2_FACTOR registered samples with ready/valid on both sides.
module interp_upsample
  import interp_pkg::*;
#(
  parameter int VAL_RES     = INTERP_VAL_RES,
  parameter int LOG2_FACTOR = INTERP_LOG2_FACTOR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VAL_RES-1:0] in_val,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [VAL_RES-1:0] out_val,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int N = interp_n(LOG2_FACTOR);
  localparam logic [LOG2_FACTOR-1:0] K_LAST = LOG2_FACTOR'(N - 1);

  state_t                 state_reg, state_next;
  logic [VAL_RES-1:0]     prev_reg, prev_next;
  logic [VAL_RES-1:0]     cur_reg, cur_next;
  logic [LOG2_FACTOR-1:0] k_reg, k_next;
  logic [VAL_RES-1:0]     out_val_reg, out_val_next;
  logic                   out_valid_reg, out_valid_next;
  logic                   in_ready_reg, in_ready_next;

  logic                   in_xfer;
  logic                   out_xfer;
  logic [LOG2_FACTOR-1:0] k_step;

  logic signed [VAL_RES:0]             diff;
  logic signed [LOG2_FACTOR:0]         k_signed;
  logic signed [VAL_RES+LOG2_FACTOR:0] prod;
  logic [VAL_RES-1:0]                  interp_val;

  assign in_xfer  = in_valid && in_ready_reg;
  assign out_xfer = out_valid_reg && out_ready;
  assign k_step   = k_reg + LOG2_FACTOR'(1);

  // Value for the step after the current one; the true sum always lies
  // between prev and cur, so truncating to VAL_RES bits is exact.
  always_comb begin
    diff       = $signed({1'b0, cur_reg}) - $signed({1'b0, prev_reg});
    k_signed   = $signed({1'b0, k_step});
    prod       = diff * k_signed;
    interp_val = prev_reg + VAL_RES'(prod >>> LOG2_FACTOR);
  end

  always_comb begin
    state_next     = state_reg;
    prev_next      = prev_reg;
    cur_next       = cur_reg;
    k_next         = k_reg;
    out_val_next   = out_val_reg;
    out_valid_next = out_valid_reg;

    case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          prev_next  = in_val;
          state_next = PRIMED;
        end
      end
      PRIMED: begin
        if (in_xfer) begin
          cur_next       = in_val;
          k_next         = '0;
          out_val_next   = prev_reg;
          out_valid_next = 1'b1;
          state_next     = EMIT;
        end
      end
      EMIT: begin
        if (out_xfer) begin
          if (k_reg == K_LAST) begin
            // cur carries over as the first sample of the next interval.
            prev_next      = cur_reg;
            k_next         = '0;
            out_valid_next = 1'b0;
            state_next     = PRIMED;
          end else begin
            k_next       = k_step;
            out_val_next = interp_val;
          end
        end
      end
      default: state_next = EMPTY;
    endcase

    in_ready_next = (state_next != EMIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= EMPTY;
      prev_reg      <= '0;
      cur_reg       <= '0;
      k_reg         <= '0;
      out_val_reg   <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      prev_reg      <= prev_next;
      cur_reg       <= cur_next;
      k_reg         <= k_next;
      out_val_reg   <= out_val_next;
      out_valid_reg <= out_valid_next;
      in_ready_reg  <= in_ready_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_val   = out_val_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_interp_upsample.sv
// Directed and randomised checks of interp_upsample at factors 4, 2 and 16.
module tb_interp_upsample;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] in_val    [3];
  logic        in_valid  [3];
  logic        in_ready  [3];
  logic [15:0] out_val   [3];
  logic        out_valid [3];
  logic        out_ready [3];

  int checks = 0;
  int errors = 0;
  int got_q[$];
  int exp_q[$];

  always #5 clk = ~clk;

  // Instance 0: factor 4, instance 1: factor 2, instance 2: factor 16.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      localparam int L2 = (gi == 0) ? 2 : (gi == 1) ? 1 : 4;
      interp_upsample #(.VAL_RES(16), .LOG2_FACTOR(L2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_val    (in_val[gi]),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .out_val   (out_val[gi]),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi])
      );
    end
  endgenerate

  // Record every output transfer; only one instance is exercised at a time.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++)
      if (out_valid[i] && out_ready[i]) got_q.push_back(int'(out_val[i]));
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, expv);
    end else begin
      $display("ok   %s got %0d", tag, got);
    end
  endtask

  task automatic send(input int i, input logic [15:0] v);
    int n = 0;
    in_val[i]   = v;
    in_valid[i] = 1'b1;
    while (!in_ready[i] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready[i]) check_val("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    foreach (exp_q[j]) begin
      if (got_q.size() == 0) check_val({tag, "_missing"}, 32'd0, 32'd1);
      else check_val(tag, got_q.pop_front(), exp_q[j]);
    end
    exp_q = {};
  endtask

  initial begin
    int s_prev;
    int s_cur;
    int dprod;
    for (int i = 0; i < 3; i++) begin
      in_val[i] = '0; in_valid[i] = 1'b0; out_ready[i] = 1'b1;
    end

    // Reset state.
    #12;
    check_val("rst_in_ready", in_ready[0], 0);
    check_val("rst_out_valid", out_valid[0], 0);
    check_val("rst_out_val", out_val[0], 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("in_ready_after_rst", in_ready[0], 1);

    // Rising ramp; nothing emitted after the first sample alone.
    send(0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("no_out_first", got_q.size(), 0);
    send(0, 16'd100);
    exp_q = '{0, 25, 50, 75};  drain("ramp_up");
    send(0, 16'd20);
    exp_q = '{100, 80, 60, 40}; drain("ramp_down");
    send(0, 16'd3);
    exp_q = '{20, 15, 11, 7};   drain("floor_a");
    send(0, 16'd0);
    exp_q = '{3, 2, 1, 0};      drain("floor_b");
    send(0, 16'hFFFF);
    exp_q = '{0, 16383, 32767, 49151}; drain("full_up");
    send(0, 16'd0);
    exp_q = '{65535, 49151, 32767, 16383}; drain("full_down");

    // Backpressure at k=1.
    send(0, 16'd100);
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check_val("stall_val", out_val[0], 25);
      check_val("stall_valid", out_valid[0], 1);
      check_val("stall_in_ready", in_ready[0], 0);
    end
    out_ready[0] = 1'b1;
    exp_q = '{0, 25, 50, 75}; drain("stall_seq");

    // Asynchronous reset at k=2 of the interval 100 -> 200.
    send(0, 16'd200);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_val("pre_rst_val", out_val[0], 150);
    #3 rst = 1'b0;
    #1;
    check_val("async_out_valid", out_valid[0], 0);
    check_val("async_out_val", out_val[0], 0);
    check_val("async_in_ready", in_ready[0], 0);
    exp_q = '{100, 125}; drain("pre_rst_seq");
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("in_ready_rerelease", in_ready[0], 1);
    send(0, 16'd7);
    send(0, 16'd7);
    exp_q = '{7, 7, 7, 7}; drain("equal");

    // Other factors.
    send(1, 16'd0);
    send(1, 16'd16);
    exp_q = '{0, 8}; drain("factor2");
    send(2, 16'd0);
    send(2, 16'd16);
    for (int k = 0; k < 16; k++) exp_q.push_back(k);
    drain("factor16");

    // Random stream with random out_ready on the factor-4 instance.
    s_prev = 7;
    fork
      begin
        for (int j = 0; j < 6; j++) begin
          s_cur = int'($urandom_range(0, 65535));
          for (int k = 0; k < 4; k++) begin
            dprod = (s_cur - s_prev) * k;
            exp_q.push_back(s_prev + (dprod >>> 2));
          end
          send(0, 16'(s_cur));
          s_prev = s_cur;
        end
      end
      begin
        repeat (150) begin
          @(posedge clk); #1;
          out_ready[0] = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready[0] = 1'b1;
    drain("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
